// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - opcode constants, access sizes and decode helpers for the load/store unit
package mem_access_unit_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_NONE = 2'd3
    } acc_size_t;

    // SZ_NONE marks every opcode that is not a memory access
    function automatic acc_size_t op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_size = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: op_size = SZ_HALF;
            OP_LW, OP_SW:         op_size = SZ_WORD;
            default:              op_size = SZ_NONE;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_signed_load(input logic [5:0] op);
        is_signed_load = (op == OP_LB) || (op == OP_LH);
    endfunction

    // Natural alignment: halfwords on even bytes, words on word boundaries
    function automatic logic is_aligned(input acc_size_t sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: is_aligned = 1'b1;
            SZ_HALF: is_aligned = ~off[0];
            SZ_WORD: is_aligned = (off == 2'b00);
            default: is_aligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - word-wide req/ack memory bus between the load/store unit and memory
interface mem_access_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - big-endian byte-lane enables, store replication and load extract/extend
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] store_data,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sext;

    // Lane 0 is bits[31:24]; pick the addressed lane(s) and extend as the opcode asks
    always_comb begin
        be         = 4'b0000;
        store_data = 32'h0;
        load_data  = 32'h0;
        sext       = is_signed_load(opcode);
        half_sel   = off[1] ? mem_rdata[15:0] : mem_rdata[31:16];
        case (off)
            2'd0:    byte_sel = mem_rdata[31:24];
            2'd1:    byte_sel = mem_rdata[23:16];
            2'd2:    byte_sel = mem_rdata[15:8];
            default: byte_sel = mem_rdata[7:0];
        endcase
        case (op_size(opcode))
            SZ_BYTE: begin
                be         = 4'b1000 >> off;
                store_data = {4{wdata[7:0]}};
                load_data  = {{24{sext & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                be         = off[1] ? 4'b0011 : 4'b1100;
                store_data = {2{wdata[15:0]}};
                load_data  = {{16{sext & half_sel[15]}}, half_sel};
            end
            SZ_WORD: begin
                be         = 4'b1111;
                store_data = wdata;
                load_data  = mem_rdata;
            end
            default: begin
                be         = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit running one word transaction per request over req/ack
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [5:0]              opcode,
    input  logic [31:0]             addr,
    input  logic [31:0]             wdata,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             rdata,
    output logic                    misalign,
    output logic                    bus_err,
    mem_access_unit_if.master       mem
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state;
    logic [5:0]       op_q;
    logic [1:0]       off_q;
    logic [29:0]      addr_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;
    logic             we_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             misalign_q;
    logic             bus_err_q;
    logic [31:0]      rdata_q;

    logic [5:0]       la_op;
    logic [1:0]       la_off;
    logic [3:0]       la_be;
    logic [31:0]      la_store;
    logic [31:0]      la_load;

    // In IDLE the aligner decodes the incoming request; afterwards it extracts using the latched one
    assign la_op  = (state == S_IDLE) ? opcode     : op_q;
    assign la_off = (state == S_IDLE) ? addr[1:0]  : off_q;

    mem_lane_align u_lane_align (
        .opcode     (la_op),
        .off        (la_off),
        .wdata      (wdata),
        .mem_rdata  (mem.mem_rdata),
        .be         (la_be),
        .store_data (la_store),
        .load_data  (la_load)
    );

    assign busy          = (state != S_IDLE);
    assign done          = (state == S_RESP);
    assign misalign      = done & misalign_q;
    assign bus_err       = done & bus_err_q;
    assign rdata         = done ? rdata_q : 32'h0;
    assign mem.mem_req   = (state == S_REQ);
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;

    // Request FSM: accept, wait for ack or timeout, then pulse done for one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            op_q       <= 6'h0;
            off_q      <= 2'b00;
            addr_q     <= 30'h0;
            be_q       <= 4'h0;
            wdata_q    <= 32'h0;
            we_q       <= 1'b0;
            wait_cnt   <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            rdata_q    <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && (op_size(opcode) != SZ_NONE)) begin
                        op_q       <= opcode;
                        off_q      <= addr[1:0];
                        addr_q     <= addr[31:2];
                        be_q       <= la_be;
                        wdata_q    <= la_store;
                        we_q       <= is_store(opcode);
                        wait_cnt   <= '0;
                        bus_err_q  <= 1'b0;
                        rdata_q    <= 32'h0;
                        if (is_aligned(op_size(opcode), addr[1:0])) begin
                            misalign_q <= 1'b0;
                            state      <= S_REQ;
                        end else begin
                            misalign_q <= 1'b1;
                            state      <= S_RESP;
                        end
                    end
                end
                S_REQ: begin
                    if (mem.mem_ack) begin
                        if (!we_q) begin
                            rdata_q <= la_load;
                        end
                        state <= S_RESP;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        bus_err_q <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  opcode = 6'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        misalign;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    mem_access_unit_if mif ();

    mem_access_unit #(.TIMEOUT(255)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .opcode   (opcode),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .misalign (misalign),
        .bus_err  (bus_err),
        .mem      (mif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request for exactly one sampling edge; returns 1ns after that edge
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        start  = 1'b1;
        opcode = op;
        addr   = a;
        wdata  = wd;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic xact(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input int waits, input logic [31:0] rd,
                        input logic [29:0] exp_addr, input logic [3:0] exp_be, input logic exp_we,
                        input logic [31:0] exp_wd, input logic [31:0] exp_rdata);
        issue(op, a, wd);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check({tag, " wait req"}, 32'(mif.mem_req), 32'd1);
            check({tag, " wait done"}, 32'(done), 32'd0);
        end
        if (waits > 0) begin
            @(posedge clk);
            #1;
        end
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = rd;
        @(negedge clk);
        check({tag, " req"}, 32'(mif.mem_req), 32'd1);
        check({tag, " mem_addr"}, 32'(mif.mem_addr), 32'(exp_addr));
        check({tag, " mem_be"}, 32'(mif.mem_be), 32'(exp_be));
        check({tag, " mem_we"}, 32'(mif.mem_we), 32'(exp_we));
        check({tag, " mem_wdata"}, mif.mem_wdata, exp_wd);
        check({tag, " early done"}, 32'(done), 32'd0);
        @(posedge clk);
        #1;
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = 32'h0;
        @(negedge clk);
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " rdata"}, rdata, exp_rdata);
        check({tag, " misalign"}, 32'(misalign), 32'd0);
        check({tag, " bus_err"}, 32'(bus_err), 32'd0);
        check({tag, " req with done"}, 32'(mif.mem_req), 32'd0);
        @(negedge clk);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
        check({tag, " idle done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int req_cycles;
        int done_seen;

        mif.mem_ack   = 1'b0;
        mif.mem_rdata = 32'h0;

        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset req", 32'(mif.mem_req), 32'd0);
        check("reset rdata", rdata, 32'h0);
        check("reset be", 32'(mif.mem_be), 32'd0);
        check("reset addr", 32'(mif.mem_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Non-memory opcode is ignored
        issue(6'h00, 32'h0000_1000, 32'h0);
        @(negedge clk);
        check("nonmem busy", 32'(busy), 32'd0);
        check("nonmem req", 32'(mif.mem_req), 32'd0);

        xact("sw", OP_SW, 32'h0000_1000, 32'hDEAD_BEEF, 0, 32'h0,
             30'h400, 4'b1111, 1'b1, 32'hDEAD_BEEF, 32'h0);
        xact("lb", OP_LB, 32'h0000_0103, 32'h0, 3, 32'h1122_3380,
             30'h40, 4'b0001, 1'b0, 32'h0, 32'hFFFF_FF80);
        xact("lbu", OP_LBU, 32'h0000_0103, 32'h0, 3, 32'h1122_3380,
             30'h40, 4'b0001, 1'b0, 32'h0, 32'h0000_0080);
        xact("sh", OP_SH, 32'h0000_0102, 32'h0000_ABCD, 0, 32'h0,
             30'h40, 4'b0011, 1'b1, 32'hABCD_ABCD, 32'h0);
        xact("lh", OP_LH, 32'h0000_0100, 32'h0, 0, 32'h8001_0000,
             30'h40, 4'b1100, 1'b0, 32'h0, 32'hFFFF_8001);
        xact("sb", OP_SB, 32'h0000_0201, 32'h0000_005A, 1, 32'h0,
             30'h80, 4'b0100, 1'b1, 32'h5A5A_5A5A, 32'h0);
        xact("lhu", OP_LHU, 32'h0000_0202, 32'h0, 0, 32'h1234_F00D,
             30'h80, 4'b0011, 1'b0, 32'h0, 32'h0000_F00D);

        // Misaligned word load: done the very next cycle, no request
        issue(OP_LW, 32'h0000_0101, 32'h0);
        @(negedge clk);
        check("mis done", 32'(done), 32'd1);
        check("mis flag", 32'(misalign), 32'd1);
        check("mis req", 32'(mif.mem_req), 32'd0);
        check("mis rdata", rdata, 32'h0);
        check("mis bus_err", 32'(bus_err), 32'd0);
        @(negedge clk);
        check("mis idle", 32'(busy), 32'd0);
        check("mis req after", 32'(mif.mem_req), 32'd0);

        // Timeout: no ack ever; a start pulse while busy must be ignored
        issue(OP_LW, 32'h0000_0200, 32'h0);
        req_cycles = 0;
        done_seen  = 0;
        for (int i = 0; i < 400 && done_seen == 0; i++) begin
            @(negedge clk);
            if (i == 5) begin
                start  = 1'b1;
                opcode = OP_SW;
                addr   = 32'h0000_0300;
            end else begin
                start  = 1'b0;
            end
            if (mif.mem_req) req_cycles++;
            if (done) begin
                done_seen = 1;
                check("to bus_err", 32'(bus_err), 32'd1);
                check("to rdata", rdata, 32'h0);
                check("to misalign", 32'(misalign), 32'd0);
                check("to req with done", 32'(mif.mem_req), 32'd0);
                check("to we", 32'(mif.mem_we), 32'd0);
            end
        end
        start = 1'b0;
        check("to done seen", 32'(done_seen), 32'd1);
        check("to req cycles", 32'(req_cycles), 32'd255);
        @(negedge clk);
        check("to idle", 32'(busy), 32'd0);

        // Reset during REQ drops the request at once; a late ack gives nothing
        issue(OP_SW, 32'h0000_0300, 32'h1111_2222);
        @(negedge clk);
        check("rst pre req", 32'(mif.mem_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst req drop", 32'(mif.mem_req), 32'd0);
        check("rst busy drop", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mif.mem_ack = 1'b1;
        @(negedge clk);
        check("rst late ack done", 32'(done), 32'd0);
        check("rst late ack busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        mif.mem_ack = 1'b0;
        @(negedge clk);
        check("rst after done", 32'(done), 32'd0);

        xact("sw2", OP_SW, 32'h0000_0008, 32'h1234_5678, 1, 32'h0,
             30'h2, 4'b1111, 1'b1, 32'h1234_5678, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit downstream of the execute stage.
- Consumes the registered effective address (base + sign-extended offset) and the store operand, then runs one word-wide memory transaction over a req/ack handshake.
- Returns byte/halfword-extracted, sign- or zero-extended load data to writeback.
- Stalls the pipeline via `busy` while a transaction is outstanding.

Parameters:
- TIMEOUT, 255: max cycles in REQ waiting for mem_ack before aborting with bus_err; 8-bit counter width is derived from it.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request strobe; sampled only in IDLE
- opcode  in  6  MIPS primary opcode: LB/LH/LW/LBU/LHU/SB/SH/SW
- addr  in  32  byte effective address
- wdata  in  32  store operand (rt value)
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load result; valid while done=1 for loads
- misalign  out  1  with done: address not naturally aligned, no memory access made
- bus_err  out  1  with done: timeout, no ack received
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  30  word address, addr[31:2]
- mem_be  out  4  byte enables, big-endian lanes
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory accepts the write / returns read data this cycle
- mem_rdata  in  32  read data, valid with mem_ack

Behaviour:
- Reset: asynchronous, active-high. State IDLE; every output 0. Asserting rst mid-transaction drops mem_req in the same instant; a later ack is ignored.
- States: IDLE, REQ, RESP.
- IDLE:
  - Accept on start=1 with a memory opcode. Other opcodes are ignored; busy stays 0.
  - Latch opcode, addr[1:0], mem_addr, mem_be, mem_wdata and mem_we on acceptance.
  - Alignment rule: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0.
  - Misaligned: go to RESP with misalign set; mem_req is never raised.
  - Aligned: go to REQ.
- REQ:
  - mem_req=1; addr/be/wdata/we held stable until the ack cycle.
  - mem_ack=1: loads capture the extracted mem_rdata; go to RESP.
  - Timeout counter increments each REQ cycle without ack. Reaching TIMEOUT drops req and goes to RESP with bus_err=1.
- RESP:
  - done=1 for exactly one cycle; misalign/bus_err valid; rdata valid for loads, 0 for stores and errors.
  - Next state IDLE.
  - A start presented in RESP is ignored; upstream holds it while busy.
- Latency: start sampled at T, mem_req at T+1, ack at T+1+k, done at T+2+k. Minimum 2 cycles start→done; misaligned case is exactly 1 cycle.
- Byte lanes (big-endian), off = addr[1:0]:
  - Byte: lane 0 is bits[31:24], lane 3 is bits[7:0]. SB/LB/LBU mem_be = 4'b1000 >> off.
  - Half: off 0 → 1100, off 2 → 0011.
  - Word: 1111.
  - Loads drive the same be pattern with mem_we=0.
- Store data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
- Load data: select the addressed lane(s).
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes through.
- mem_ack outside REQ is ignored.
- done is never asserted together with mem_req.

Decomposition:
- Opcode constants stay in the shared INST.v define file; add nothing new there.
- State encodings are local localparams.
- One natural sub-module: mem_lane_align, a combinational block holding be generation, store replication and load extract/extend. It is reusable by a future cache fill path.

Test Plan:
- SW addr=0x0000_1000 wdata=0xDEADBEEF, ack 1st REQ cycle → mem_addr=0x400, be=1111, we=1, done at T+2, no errors.
- LB addr=0x103, mem_rdata=0x11223380, ack after 3 wait cycles → be=0001, rdata=0xFFFFFF80, done at T+5; same with LBU → 0x00000080.
- SH addr=0x102 wdata=0x0000ABCD → be=0011, mem_wdata=0xABCDABCD; LH addr=0x100 rdata=0x8001_0000 → 0xFFFF8001.
- LW addr=0x101 → misalign=1 and done at T+1, mem_req stays 0 throughout, rdata=0.
- Load with ack never asserted, TIMEOUT=255 → mem_req high 255 cycles, then done+bus_err; a start during busy is ignored.
- rst pulsed while in REQ → mem_req/busy drop immediately; ack one cycle later gives no done; next SW completes normally.
